if_fetch_queue: RTL and testbench

//  Instruction-fetch stage with a small prefetch queue; the producer side of the

---
 rtl/if_fetch_queue.sv | 147 ++++++++++++++
 tb/tb_if_fetch_queue.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction-fetch stage with a small prefetch queue.
// Generates sequential fetch PCs, reads instruction memory (one-cycle read
// latency), buffers {PC, instr} pairs, and presents the head entry to decode
// with Op/funct3/funct7 sliced out. A redirect from Execute flushes the queue.
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   imem_req/imem_addr       fetch request and word-aligned address
//   imem_rdata               read data, valid the cycle after imem_req
//   PCSrcE/PCTargetE         redirect from Execute and its target
//   StallD                   decode stall, holds the head entry
//   ValidD/InstrD/PCD/PCPlus4D  head entry presented to decode
//   Op/funct3/funct7         decoded fields of InstrD
//   count                    entries currently held in the queue
module if_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       PCSrcE,
  input  logic [31:0]                PCTargetE,
  input  logic                       StallD,
  output logic                       ValidD,
  output logic [31:0]                InstrD,
  output logic [31:0]                PCD,
  output logic [31:0]                PCPlus4D,
  output logic [6:0]                 Op,
  output logic [2:0]                 funct3,
  output logic [6:0]                 funct7,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
  localparam logic [31:0] Nop = 32'h0000_0013;

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            inflight_q, inflight_d;
  logic [31:0]     inflight_pc_q, inflight_pc_d;
  logic            squash_q, squash_d;

  logic [31:0] pc_mem_q    [DEPTH];
  logic [31:0] instr_mem_q [DEPTH];

  logic            valid;
  logic [CntW-1:0] credit;
  logic            req;
  logic            push;
  logic            pop;

  always_comb begin
    valid  = (count_q != '0);
    // An outstanding request already owns a slot; a same-cycle pop is not credited.
    credit = count_q + CntW'(inflight_q);
    req    = rst & ~PCSrcE & (credit < DepthC);
    push   = inflight_q & ~squash_q & ~PCSrcE;
    pop    = valid & ~StallD & ~PCSrcE;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    inflight_d    = req;
    inflight_pc_d = req ? fetch_pc_q : inflight_pc_q;
    squash_d      = 1'b0;

    if (req) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (PCSrcE) begin
      // Redirect wins over stall and pop; everything buffered is stale.
      fetch_pc_d = PCTargetE & ~32'h3;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      squash_d   = inflight_q;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      squash_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      squash_q      <= squash_d;
    end
  end

  // Queue storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  always_comb begin
    imem_req  = req;
    imem_addr = fetch_pc_q;
    ValidD    = valid;
    InstrD    = valid ? instr_mem_q[rd_ptr_q] : Nop;
    PCD       = valid ? pc_mem_q[rd_ptr_q] : 32'h0;
    PCPlus4D  = valid ? (pc_mem_q[rd_ptr_q] + 32'd4) : 32'h0;
    Op        = InstrD[6:0];
    funct3    = InstrD[14:12];
    funct7    = InstrD[31:25];
    count     = count_q;
  end

  push_not_full_a: assert property (@(posedge clk) disable iff (!rst)
    !(push && (count_q == DepthC)));

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

  logic        clk;
  logic        rst;
  logic        StallD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        ValidD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic [6:0]  Op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [2:0]  count;

  // Second instance exercising address wrap at the top of memory.
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_pc4;
  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [2:0]  w_count;
  logic        w_stall;
  logic        w_pcsrc;
  logic [31:0] w_target;

  int total;
  int bad;
  logic [31:0] sb[$];

  if_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0100)) u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
    .ValidD(ValidD), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .Op(Op),
    .funct3(funct3), .funct7(funct7), .count(count)
  );

  if_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .PCSrcE(w_pcsrc), .PCTargetE(w_target), .StallD(w_stall),
    .ValidD(w_valid), .InstrD(w_instr), .PCD(w_pc), .PCPlus4D(w_pc4), .Op(w_op),
    .funct3(w_f3), .funct7(w_f7), .count(w_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: data = address ^ 0xA5A5_0000, one-cycle latency.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? (imem_addr ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
    w_rdata    <= w_req ? (w_addr ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every entry accepted by decode must be the next expected PC.
  always @(negedge clk) begin
    if (rst && ValidD && !StallD && !PCSrcE) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_pop", PCD, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] epc;
        logic [31:0] ein;
        epc = sb.pop_front();
        ein = epc ^ 32'hA5A5_0000;
        chk("sb_pcd", PCD, epc);
        chk("sb_instr", InstrD, ein);
        chk("sb_pcplus4", PCPlus4D, epc + 32'd4);
        chk("sb_op", {25'd0, Op}, {25'd0, ein[6:0]});
        chk("sb_funct3", {29'd0, funct3}, {29'd0, ein[14:12]});
        chk("sb_funct7", {25'd0, funct7}, {25'd0, ein[31:25]});
      end
    end
  end

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    StallD = 1'b0;
    PCSrcE = 1'b0;
    PCTargetE = 32'h0;
    w_stall = 1'b0;
    w_pcsrc = 1'b0;
    w_target = 32'h0;

    repeat (3) tick();
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, ValidD}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_instr_nop", InstrD, 32'h0000_0013);
    chk("rst_pcd", PCD, 32'h0);
    chk("rst_pcplus4", PCPlus4D, 32'h0);
    chk("rst_op", {25'd0, Op}, 32'h13);
    chk("rst_funct3", {29'd0, funct3}, 32'd0);
    chk("rst_funct7", {25'd0, funct7}, 32'd0);

    // Sequential fetch from RESET_PC, then a long decode stall.
    tick(); rst = 1'b1;
    for (int i = 0; i < 8; i++) sb.push_back(32'h100 + 32'(i) * 4);
    #1;
    chk("c0_req", {31'd0, imem_req}, 32'd1);
    chk("c0_addr", imem_addr, 32'h100);
    chk("c0_valid", {31'd0, ValidD}, 32'd0);
    chk("w_c0_addr", w_addr, 32'hFFFF_FFF8);
    tick(); #1;
    chk("c1_addr", imem_addr, 32'h104);
    chk("c1_valid", {31'd0, ValidD}, 32'd0);
    chk("w_c1_addr", w_addr, 32'hFFFF_FFFC);
    tick(); #1;
    chk("c2_valid", {31'd0, ValidD}, 32'd1);
    chk("c2_pcd", PCD, 32'h100);
    chk("c2_pcplus4", PCPlus4D, 32'h104);
    chk("c2_addr", imem_addr, 32'h108);
    chk("w_c2_addr", w_addr, 32'h0);
    chk("w_c2_pcd", w_pc, 32'hFFFF_FFF8);
    tick(); #1;
    chk("c3_pcd", PCD, 32'h104);
    chk("c3_count", {29'd0, count}, 32'd1);
    chk("w_c3_pcd", w_pc, 32'hFFFF_FFFC);
    chk("w_c3_pcplus4", w_pc4, 32'h0);
    tick(); StallD = 1'b1; #1;
    chk("c4_pcd", PCD, 32'h108);
    for (int c = 5; c <= 13; c++) begin
      tick(); #1;
      if (c == 7) chk("stall_req_off", {31'd0, imem_req}, 32'd0);
    end
    chk("stall_count_full", {29'd0, count}, 32'd4);
    chk("stall_req", {31'd0, imem_req}, 32'd0);
    chk("stall_pcd_frozen", PCD, 32'h108);
    tick(); StallD = 1'b0; #1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        tick(); #1;
      end
      chk("drain_valid", {31'd0, ValidD}, 32'd1);
      chk("drain_pcd", PCD, 32'h108 + 32'(k) * 4);
    end

    // Redirect with count=3 and a request in flight.
    tick(); StallD = 1'b1; #1;
    chk("c20_count", {29'd0, count}, 32'd2);
    tick(); StallD = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h203;
    sb.push_back(32'h200);
    sb.push_back(32'h204);
    #1;
    chk("redir_count_pre", {29'd0, count}, 32'd3);
    chk("redir_req_off", {31'd0, imem_req}, 32'd0);
    tick(); PCSrcE = 1'b0; #1;
    chk("redir_valid", {31'd0, ValidD}, 32'd0);
    chk("redir_count", {29'd0, count}, 32'd0);
    chk("redir_req", {31'd0, imem_req}, 32'd1);
    chk("redir_addr", imem_addr, 32'h200);
    chk("sb_left_before_redir", 32'(sb.size()), 32'd2);
    tick(); #1;
    chk("redir2_valid", {31'd0, ValidD}, 32'd0);
    chk("redir2_instr_nop", InstrD, 32'h0000_0013);
    chk("redir2_addr", imem_addr, 32'h204);
    tick(); #1;
    chk("redir3_valid", {31'd0, ValidD}, 32'd1);
    chk("redir3_pcd", PCD, 32'h200);
    tick(); #1;
    chk("redir4_pcd", PCD, 32'h204);

    // Redirect together with a decode stall.
    tick(); PCSrcE = 1'b1; StallD = 1'b1; PCTargetE = 32'h300; #1;
    chk("rs_req_off", {31'd0, imem_req}, 32'd0);
    tick(); PCSrcE = 1'b0; StallD = 1'b0; #1;
    chk("rs_valid", {31'd0, ValidD}, 32'd0);
    chk("rs_count", {29'd0, count}, 32'd0);
    chk("rs_addr", imem_addr, 32'h300);
    chk("sb_empty_mid", 32'(sb.size()), 32'd0);
    tick(); #1;
    chk("rs2_valid", {31'd0, ValidD}, 32'd0);
    tick(); StallD = 1'b1; #1;
    chk("rs3_valid", {31'd0, ValidD}, 32'd1);
    chk("rs3_pcd", PCD, 32'h300);

    // One-cycle reset with count=2 and a request in flight.
    tick(); rst = 1'b0; #1;
    chk("mid_count_pre", {29'd0, count}, 32'd2);
    chk("mid_req_gated", {31'd0, imem_req}, 32'd0);
    tick(); rst = 1'b1; StallD = 1'b0;
    sb.push_back(32'h100);
    sb.push_back(32'h104);
    sb.push_back(32'h108);
    #1;
    chk("mid_count", {29'd0, count}, 32'd0);
    chk("mid_valid", {31'd0, ValidD}, 32'd0);
    chk("mid_req", {31'd0, imem_req}, 32'd1);
    chk("mid_addr", imem_addr, 32'h100);
    tick(); #1;
    chk("mid2_valid", {31'd0, ValidD}, 32'd0);
    tick(); #1;
    chk("mid3_valid", {31'd0, ValidD}, 32'd1);
    chk("mid3_pcd", PCD, 32'h100);
    tick(); #1;
    tick(); #1;
    tick(); StallD = 1'b1; #1;
    chk("sb_empty_end", 32'(sb.size()), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
